// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame receiver.
// State encoding, line levels and the even-parity convention.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b0;
    localparam logic START_LEVEL = 1'b1;

    // Even parity: the ones across data+parity must be even.
    function automatic logic even_par_err(
        input logic data_xor,
        input logic par_bit
    );
        return data_xor ^ par_bit;
    endfunction

endpackage

// File: rtl/frame_output_slot.sv
// One-entry valid/ready holding register for received frames.
// A frame arriving while the slot is occupied is dropped and flagged.
module frame_output_slot #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_err,
    input  logic             i_ready,
    input  logic             i_ovr_clr,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_err,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_err;
    logic             r_overrun;
    logic             w_slot_free;

    assign w_slot_free = !r_valid || i_ready;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_load && w_slot_free) begin
                r_data  <= i_data;
                r_err   <= i_err;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            // A new drop outranks a clear on the same edge.
            if (i_load && !w_slot_free) begin
                r_overrun <= 1'b1;
            end else if (i_ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_err     = r_err;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_frame_receiver.sv
// Start-bit framed, MSB-first, even-parity serial deserialiser
// with a valid/ready parallel output and sticky overrun flag.
module serial_frame_receiver
    import serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             SerialIn,
    input  logic             BitValid,
    input  logic             OutReady,
    input  logic             OverrunClr,
    output logic [WIDTH-1:0] ParallelOut,
    output logic             OutValid,
    output logic             ParityErr,
    output logic             Overrun,
    output logic             Busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sreg;
    logic             w_load;
    logic             w_err;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sreg  <= '0;
        end else if (BitValid) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (SerialIn == START_LEVEL) begin
                        r_state <= ST_DATA;
                        r_cnt   <= '0;
                    end
                end
                ST_DATA: begin
                    r_sreg <= {r_sreg[WIDTH-2:0], SerialIn};
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_PARITY;
                    end
                end
                ST_PARITY: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_load = BitValid && (r_state == ST_PARITY);
    assign w_err  = even_par_err(^r_sreg, SerialIn);
    assign Busy   = (r_state != ST_IDLE);

    frame_output_slot #(
        .WIDTH(WIDTH)
    ) u_slot (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .i_load   (w_load),
        .i_data   (r_sreg),
        .i_err    (w_err),
        .i_ready  (OutReady),
        .i_ovr_clr(OverrunClr),
        .o_data   (ParallelOut),
        .o_valid  (OutValid),
        .o_err    (ParityErr),
        .o_overrun(Overrun)
    );

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver (WIDTH=4):
// per-cycle vector table plus reset and upstream-chain sequences.
module tb_serial_frame_receiver;

    logic       Clk;
    logic       Reset_n;
    logic       SerialIn;
    logic       BitValid;
    logic       OutReady;
    logic       OverrunClr;
    logic [3:0] ParallelOut;
    logic       OutValid;
    logic       ParityErr;
    logic       Overrun;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      nm;
        logic       bv, s, r, c;
        logic       v;
        logic [3:0] d;
        logic       e, o, b;
    } vec_t;

    vec_t tbl[$];

    // Expected held output state while building the table.
    logic       pv, pe, po;
    logic [3:0] pd;

    serial_frame_receiver #(.WIDTH(4)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .SerialIn   (SerialIn),
        .BitValid   (BitValid),
        .OutReady   (OutReady),
        .OverrunClr (OverrunClr),
        .ParallelOut(ParallelOut),
        .OutValid   (OutValid),
        .ParityErr  (ParityErr),
        .Overrun    (Overrun),
        .Busy       (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic v, input logic [3:0] d,
                       input logic e, input logic o, input logic b);
        checks++;
        if ({OutValid, ParallelOut, ParityErr, Overrun, Busy} !== {v, d, e, o, b}) begin
            errors++;
            $display("FAIL %s: got v=%b d=%h e=%b o=%b b=%b, want v=%b d=%h e=%b o=%b b=%b",
                     nm, OutValid, ParallelOut, ParityErr, Overrun, Busy, v, d, e, o, b);
        end
    endtask

    task automatic add(input string nm, input logic bv, input logic s,
                       input logic r, input logic c, input logic v,
                       input logic [3:0] d, input logic e, input logic o,
                       input logic b);
        vec_t x;
        x.nm = nm; x.bv = bv; x.s = s; x.r = r; x.c = c;
        x.v = v; x.d = d; x.e = e; x.o = o; x.b = b;
        tbl.push_back(x);
    endtask

    // f = {start, d3..d0, parity}; final row carries the given ready/clear
    // and hand-computed outputs, earlier rows expect held outputs and Busy.
    task automatic send(input string nm, input logic [5:0] f, input int gap,
                        input logic r, input logic c, input logic v,
                        input logic [3:0] d, input logic e, input logic o);
        for (int i = 5; i >= 0; i--) begin
            if (i == 0) begin
                add(nm, 1'b1, f[0], r, c, v, d, e, o, 1'b0);
            end else begin
                add(nm, 1'b1, f[i], 1'b0, 1'b0, pv, pd, pe, po, 1'b1);
                for (int g = 0; g < gap; g++)
                    add({nm, "_gap"}, 1'b0, 1'b1, 1'b0, 1'b0, pv, pd, pe, po, 1'b1);
            end
        end
        pv = v; pd = d; pe = e; po = o;
    endtask

    task automatic consume(input string nm);
        add(nm, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, pd, pe, po, 1'b0);
        pv = 1'b0;
    endtask

    task automatic clr(input string nm);
        add(nm, 1'b0, 1'b0, 1'b0, 1'b1, pv, pd, pe, 1'b0, 1'b0);
        po = 1'b0;
    endtask

    task automatic drive(input logic bv, input logic s, input logic r, input logic c);
        BitValid = bv; SerialIn = s; OutReady = r; OverrunClr = c;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [3:0] up;
        Reset_n = 1'b0; SerialIn = 1'b0; BitValid = 1'b0;
        OutReady = 1'b0; OverrunClr = 1'b0;
        pv = 1'b0; pd = 4'h0; pe = 1'b0; po = 1'b0;

        send("nominal", 6'b1_1010_0, 0, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
        consume("nominal_take");
        send("parerr", 6'b1_0111_0, 0, 1'b0, 1'b0, 1'b1, 4'h7, 1'b1, 1'b0);
        consume("parerr_take");
        for (int i = 0; i < 3; i++)
            add("idle0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 1'b1, 1'b0, 1'b0);
        send("gaps", 6'b1_1100_0, 2, 1'b0, 1'b0, 1'b1, 4'hC, 1'b0, 1'b0);
        consume("gaps_take");
        send("holdA", 6'b1_1010_0, 0, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
        send("ovr5", 6'b1_0101_0, 0, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b1);
        clr("ovr_clr");
        send("same3", 6'b1_0011_0, 0, 1'b1, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
        send("b2b_ovr_clr", 6'b1_0101_0, 0, 1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b1);
        clr("ovr_clr2");
        consume("take3");

        #12;
        chk("reset_state", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].bv, tbl[i].s, tbl[i].r, tbl[i].c);
            chk(tbl[i].nm, tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].o, tbl[i].b);
        end

        // Reset mid-frame after start + two data bits.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_reset", 1'b0, 4'h3, 1'b0, 1'b0, 1'b1);
        #2 Reset_n = 1'b0;
        #1 chk("mid_reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_reset_busy", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_reset_9", 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("take9", 1'b0, 4'h9, 1'b0, 1'b0, 1'b0);

        // Upstream 4-bit PISO loaded with 1111, shifting in zeros.
        up = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            BitValid = 1'b1; SerialIn = up[3];
            OutReady = 1'b0; OverrunClr = 1'b0;
            @(posedge Clk);
            up = {up[2:0], 1'b0};
            #1;
            if (i == 4) chk("chain_latency", 1'b0, 4'h9, 1'b0, 1'b0, 1'b1);
        end
        chk("chain_E", 1'b1, 4'hE, 1'b1, 1'b0, 1'b0);
        BitValid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
